// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: queues add/sub requests and runs them through FPU_32b one
// at a time. Operands are held for the FPU latency, the result and flags are
// captured, and they are returned on a valid/ready response port.
module fpu_issue_ctrl #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned FPU_LATENCY = 8
) (
    input  logic        clk_i,
    input  logic        RST,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_opa_i,
    input  logic [31:0] req_opb_i,
    input  logic        req_op_i,
    input  logic [1:0]  req_mode_i,
    output logic [31:0] fpu_opa_o,
    output logic [31:0] fpu_opb_o,
    output logic        fpu_op_o,
    output logic [1:0]  fpu_mode_o,
    input  logic [31:0] fpu_result_i,
    input  logic [4:0]  fpu_flags_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_result_o,
    output logic [4:0]  rsp_flags_o,
    output logic        busy_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned LAT_W = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;

    typedef struct packed {
        logic [31:0] opa;
        logic [31:0] opb;
        logic        op;
        logic [1:0]  mode;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [LAT_W-1:0]   lat_cnt_q;
    state_t             state_q;
    state_t             state_d;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    entry_t             head;
    entry_t             wr_entry;

    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    // Ready depends only on the registered count, never on rsp_ready_i.
    assign req_ready_o = !RST && !full;
    assign push        = req_valid_i && req_ready_o;
    assign head        = mem[rd_ptr_q];
    assign wr_entry    = '{opa: req_opa_i, opb: req_opb_i, op: req_op_i, mode: req_mode_i};
    assign busy_o      = (state_q != IDLE) || !empty;

    // Request storage; contents need no reset since count gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and pop decision; RESP chains straight into the next WAIT.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand issue, latency counter and response capture.
    always_ff @(posedge clk_i or posedge RST) begin
        if (RST) begin
            fpu_opa_o    <= '0;
            fpu_opb_o    <= '0;
            fpu_op_o     <= 1'b0;
            fpu_mode_o   <= '0;
            lat_cnt_q    <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_result_o <= '0;
            rsp_flags_o  <= '0;
        end else begin
            if (pop) begin
                fpu_opa_o  <= head.opa;
                fpu_opb_o  <= head.opb;
                fpu_op_o   <= head.op;
                fpu_mode_o <= head.mode;
                lat_cnt_q  <= LAT_W'(FPU_LATENCY - 1);
            end else if (state_q == WAIT && lat_cnt_q != '0) begin
                lat_cnt_q  <= lat_cnt_q - LAT_W'(1);
            end

            if (state_q == CAPTURE) begin
                rsp_result_o <= fpu_result_i;
                rsp_flags_o  <= fpu_flags_i;
                rsp_valid_o  <= 1'b1;
            end else if (state_q == RESP && rsp_ready_i) begin
                rsp_valid_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Testbench for fpu_issue_ctrl with a behavioural FPU_32b stand-in that only
// produces a valid result once its operands have been stable long enough.
module tb_fpu_issue_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT   = 8;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_opa;
    logic [31:0] req_opb;
    logic        req_op;
    logic [1:0]  req_mode;
    logic [31:0] fpu_opa;
    logic [31:0] fpu_opb;
    logic        fpu_op;
    logic [1:0]  fpu_mode;
    logic [31:0] fpu_result;
    logic [4:0]  fpu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_flags;
    logic        busy;

    int unsigned n_tests = 0;
    int unsigned n_fails = 0;

    fpu_issue_ctrl #(.DEPTH(DEPTH), .FPU_LATENCY(LAT)) dut (
        .clk_i        (clk),
        .RST          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_opa_i    (req_opa),
        .req_opb_i    (req_opb),
        .req_op_i     (req_op),
        .req_mode_i   (req_mode),
        .fpu_opa_o    (fpu_opa),
        .fpu_opb_o    (fpu_opb),
        .fpu_op_o     (fpu_op),
        .fpu_mode_o   (fpu_mode),
        .fpu_result_i (fpu_result),
        .fpu_flags_i  (fpu_flags),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_flags_o  (rsp_flags),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hand-computed IEEE-754 sums for the directed vectors; any other input
    // gets an arbitrary deterministic stand-in value.
    function automatic logic [31:0] fpu_res(input logic [31:0] a, input logic [31:0] b, input logic op);
        if (!op && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
        if ( op && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
        if (!op && a == 32'h40200000 && b == 32'h40200000) return 32'h40A00000;
        if ( op && a == 32'h41200000 && b == 32'h41200000) return 32'h00000000;
        if (!op && a == 32'h00000000 && b == 32'h41200000) return 32'h41200000;
        return op ? (a ^ {b[15:0], b[31:16]}) : (a + b);
    endfunction

    function automatic logic [4:0] fpu_flg(input logic [31:0] r);
        return {r[0], r[1], r[2], (r[30:23] == 8'hFF), (r[30:0] == 31'd0)};
    endfunction

    // FPU stand-in: garbage until operands have been held for LAT cycles.
    logic [66:0] cur_ops;
    logic [66:0] seen_ops = '1;
    int unsigned stable   = 0;
    logic        fpu_ok;
    assign cur_ops = {fpu_opa, fpu_opb, fpu_op, fpu_mode};
    always @(posedge clk) begin
        if (cur_ops !== seen_ops) begin
            seen_ops <= cur_ops;
            stable   <= 0;
        end else if (stable < 1000) begin
            stable   <= stable + 1;
        end
    end
    assign fpu_ok     = (cur_ops === seen_ops) && (stable >= LAT - 1);
    assign fpu_result = fpu_ok ? fpu_res(fpu_opa, fpu_opb, fpu_op) : 32'hDEADBEEF;
    assign fpu_flags  = fpu_ok ? fpu_flg(fpu_res(fpu_opa, fpu_opb, fpu_op)) : 5'h1F;

    // Scoreboard: expected responses in request order, flushed by reset.
    logic [36:0] sb[$];
    logic [31:0] got_log[$];
    logic [4:0]  got_flg[$];
    int unsigned n_rsp = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sb.delete();
        end else begin
            logic [31:0] r;
            logic [36:0] e;
            if (req_valid && req_ready) begin
                r = fpu_res(req_opa, req_opb, req_op);
                sb.push_back({r, fpu_flg(r)});
            end
            if (rsp_valid && rsp_ready) begin
                got_log.push_back(rsp_result);
                got_flg.push_back(rsp_flags);
                n_rsp++;
                check("rsp_expected", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rsp_result", 64'(rsp_result), 64'(e[36:5]));
                    check("rsp_flags", 64'(rsp_flags), 64'(e[4:0]));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op, input logic [1:0] mode);
        int unsigned k;
        logic acc;
        req_opa   = a;
        req_opb   = b;
        req_op    = op;
        req_mode  = mode;
        req_valid = 1'b1;
        k = 0;
        forever begin
            acc = req_ready;
            @(posedge clk);
            if (acc) break;
            @(negedge clk);
            k++;
            if (k > 300) begin
                check("send_timeout", 64'(k), 64'(0));
                break;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_log(input int unsigned n, input string tag);
        int unsigned k;
        k = 0;
        while (got_log.size() < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(got_log.size()), 64'(n));
    endtask

    task automatic wait_idle(input string tag);
        int unsigned k;
        k = 0;
        while (busy && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(busy), 64'(0));
    endtask

    initial begin
        int unsigned c;
        int unsigned acc_n;
        int unsigned n0;
        logic        a;
        logic        changed;
        logic [31:0] s_res;
        logic [4:0]  s_flg;
        logic [66:0] s_ops;
        logic        done;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_opa   = '0;
        req_opb   = '0;
        req_op    = 1'b0;
        req_mode  = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_result", 64'(rsp_result), 64'(0));
        check("rst_rsp_flags", 64'(rsp_flags), 64'(0));
        check("rst_fpu_ops", 64'(cur_ops), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("rel_req_ready", 64'(req_ready), 64'(1));

        // Test 1: single request, latency N+LAT+2
        got_log.delete();
        req_opa = 32'h3F800000; req_opb = 32'h3F800000; req_op = 1'b0; req_mode = 2'd1;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        c = 0;
        while (!rsp_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("t1_latency", 64'(c), 64'(LAT + 2));
        check("t1_result", 64'(rsp_result), 64'h40000000);
        check("t1_zero_flag", 64'(rsp_flags[0]), 64'(0));
        check("t1_mode_pass", 64'(fpu_mode), 64'(1));
        wait_log(1, "t1_count");
        wait_idle("t1_idle");

        // Test 2: four back-to-back requests
        got_log.delete();
        got_flg.delete();
        send(32'h3F800000, 32'h3F800000, 1'b0, 2'd0);
        send(32'h40400000, 32'h3F800000, 1'b1, 2'd0);
        send(32'h40200000, 32'h40200000, 1'b0, 2'd0);
        send(32'h41200000, 32'h41200000, 1'b1, 2'd0);
        wait_log(4, "t2_count");
        if (got_log.size() == 4) begin
            check("t2_r0", 64'(got_log[0]), 64'h40000000);
            check("t2_r1", 64'(got_log[1]), 64'h40000000);
            check("t2_r2", 64'(got_log[2]), 64'h40A00000);
            check("t2_r3", 64'(got_log[3]), 64'h00000000);
            check("t2_zero3", 64'(got_flg[3][0]), 64'(1));
        end
        wait_idle("t2_idle");

        // Test 3: backpressure, DEPTH queued plus one in flight
        n0 = n_rsp;
        rsp_ready = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 12; i++) begin
            req_opa = 32'h40000000 + 32'(acc_n);
            req_opb = 32'h00001000 + 32'(acc_n);
            req_op = 1'b0;
            req_mode = 2'd2;
            req_valid = 1'b1;
            a = req_ready;
            @(posedge clk);
            if (a) acc_n++;
            @(negedge clk);
        end
        check("t3_accepted", 64'(acc_n), 64'(DEPTH + 1));
        check("t3_ready_low", 64'(req_ready), 64'(0));
        check("t3_busy", 64'(busy), 64'(1));

        // Test 4: held response stays stable, nothing popped
        c = 0;
        while (!rsp_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("t4_rsp_valid", 64'(rsp_valid), 64'(1));
        s_res = rsp_result;
        s_flg = rsp_flags;
        s_ops = cur_ops;
        changed = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_result !== s_res || rsp_flags !== s_flg || cur_ops !== s_ops ||
                req_ready !== 1'b0 || rsp_valid !== 1'b1)
                changed = 1'b1;
        end
        check("t4_stable", 64'(changed), 64'(0));
        check("t4_first_result", 64'(s_res), 64'(fpu_res(32'h40000000, 32'h00001000, 1'b0)));
        rsp_ready = 1'b1;
        c = 0;
        forever begin
            a = req_ready;
            @(posedge clk);
            if (a) break;
            @(negedge clk);
            c++;
            if (c > 300) begin
                check("t3_release_timeout", 64'(c), 64'(0));
                break;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle("t3_idle");
        check("t3_rsp_count", 64'(n_rsp - n0), 64'(DEPTH + 2));

        // Test 5: reset during WAIT with two queued
        send(32'h3F800000, 32'h40000000, 1'b0, 2'd3);
        send(32'h40400000, 32'h40800000, 1'b1, 2'd1);
        send(32'h40A00000, 32'h40C00000, 1'b0, 2'd2);
        repeat (2) @(negedge clk);
        check("t5_busy_pre", 64'(busy), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("t5_rsp_valid", 64'(rsp_valid), 64'(0));
        check("t5_rsp_result", 64'(rsp_result), 64'(0));
        check("t5_fpu_ops", 64'(cur_ops), 64'(0));
        check("t5_busy", 64'(busy), 64'(0));
        check("t5_req_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        n0 = n_rsp;
        repeat (30) @(negedge clk);
        check("t5_no_rsp", 64'(n_rsp - n0), 64'(0));
        check("t5_idle", 64'(busy), 64'(0));
        got_log.delete();
        send(32'h00000000, 32'h41200000, 1'b0, 2'd0);
        wait_log(1, "t5_count");
        if (got_log.size() == 1) check("t5_result", 64'(got_log[0]), 64'h41200000);
        wait_idle("t5_idle_end");

        // Test 6: random valid gaps and random consumer backpressure
        n0 = n_rsp;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    send($urandom, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rsp_ready = 1'b1;
        wait_idle("t6_idle");
        check("t6_rsp_count", 64'(n_rsp - n0), 64'(200));
        check("t6_sb_empty", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
